// File: rtl/dps_uart2.sv
`default_nettype none
// ============================================================================
// Module   : dps_uart2
// Purpose  : Second-generation DPS UART. 16x oversampled baud generator,
//            runtime frame format (5-8 data bits, none/even/odd parity,
//            1 or 2 stop bits), TX/RX FIFOs of P_DEPTH entries, per-byte
//            parity/framing flags, sticky overrun flag, maskable IRQ.
// Ports    : iCLOCK/inRESET        clock, async active-low reset
//            iDIVISOR              oversample tick period minus 1
//            iDATA_BITS/iPARITY_*  frame format, iSTOP2 two TX stop bits
//            iTX_* / oTX_*         TX FIFO write side and status
//            iRX_* / oRX_*         RX FIFO read side (show-ahead) and status
//            iERR_CLEAR            clears oRX_OVERRUN
//            iIRQ_*_EN/oIRQ_VALID  interrupt enables and registered level
//            oUART_TXD/iUART_RXD   serial pins
// Revision : 1.0 - initial release
// ============================================================================
module dps_uart2 #(
  parameter int P_DEPTH   = 16,
  parameter int P_DEPTH_N = 4,
  parameter int P_DIV_W   = 16
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic [P_DIV_W-1:0]   iDIVISOR,
  input  logic [1:0]           iDATA_BITS,
  input  logic                 iPARITY_EN,
  input  logic                 iPARITY_ODD,
  input  logic                 iSTOP2,
  input  logic                 iTX_EN,
  input  logic                 iTX_CLEAR,
  input  logic                 iTX_REQ,
  input  logic [7:0]           iTX_DATA,
  output logic                 oTX_FULL,
  output logic [P_DEPTH_N:0]   oTX_BUFF_CNT,
  output logic                 oTX_IDLE,
  input  logic                 iRX_EN,
  input  logic                 iRX_CLEAR,
  input  logic                 iRX_REQ,
  output logic                 oRX_EMPTY,
  output logic [7:0]           oRX_DATA,
  output logic                 oRX_PERR,
  output logic                 oRX_FERR,
  output logic [P_DEPTH_N:0]   oRX_BUFF_CNT,
  output logic                 oRX_OVERRUN,
  input  logic                 iERR_CLEAR,
  input  logic                 iIRQ_RX_EN,
  input  logic                 iIRQ_TX_EN,
  output logic                 oIRQ_VALID,
  output logic                 oUART_TXD,
  input  logic                 iUART_RXD
);

  // Shared by both serial FSMs.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [P_DIV_W-1:0] BAUD_ONE = P_DIV_W'(1);

  // --------------------------------------------------------------------------
  // Baud generator: one-clock tick every iDIVISOR+1 clocks
  // --------------------------------------------------------------------------
  logic [P_DIV_W-1:0] baud_cnt_q;
  logic               w_tick;

  assign w_tick = (baud_cnt_q == iDIVISOR);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)    baud_cnt_q <= '0;
    else if (w_tick) baud_cnt_q <= '0;
    else             baud_cnt_q <= baud_cnt_q + BAUD_ONE;
  end

  // --------------------------------------------------------------------------
  // FIFOs
  // --------------------------------------------------------------------------
  logic       w_tx_load;
  logic [7:0] w_tx_head;
  logic       w_tx_empty;
  logic       w_rx_wr;
  logic [9:0] w_rx_entry;
  logic [9:0] w_rx_head;
  logic       w_rx_full;

  dps_uart2_fifo #(.P_W(8), .P_DEPTH(P_DEPTH), .P_DEPTH_N(P_DEPTH_N)) u_tx_fifo (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .clear_i (iTX_CLEAR),
    .push_i  (iTX_EN && iTX_REQ),
    .data_i  (iTX_DATA),
    .pop_i   (w_tx_load),
    .data_o  (w_tx_head),
    .cnt_o   (oTX_BUFF_CNT),
    .full_o  (oTX_FULL),
    .empty_o (w_tx_empty)
  );

  dps_uart2_fifo #(.P_W(10), .P_DEPTH(P_DEPTH), .P_DEPTH_N(P_DEPTH_N)) u_rx_fifo (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .clear_i (iRX_CLEAR),
    .push_i  (w_rx_wr),
    .data_i  (w_rx_entry),
    .pop_i   (iRX_EN && iRX_REQ),
    .data_o  (w_rx_head),
    .cnt_o   (oRX_BUFF_CNT),
    .full_o  (w_rx_full),
    .empty_o (oRX_EMPTY)
  );

  assign oRX_DATA = oRX_EMPTY ? 8'h00 : w_rx_head[7:0];
  assign oRX_PERR = oRX_EMPTY ? 1'b0  : w_rx_head[8];
  assign oRX_FERR = oRX_EMPTY ? 1'b0  : w_rx_head[9];

  // --------------------------------------------------------------------------
  // Transmitter. Format is latched at load so mid-frame changes are ignored.
  // --------------------------------------------------------------------------
  logic [2:0] tx_state_q, tx_state_d;
  logic [4:0] tx_tick_q,  tx_tick_d;   // 5 bits to cover a 32-tick double stop
  logic [2:0] tx_bit_q,   tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [1:0] tx_bits_q,  tx_bits_d;
  logic       tx_pen_q,   tx_pen_d;
  logic       tx_par_q,   tx_par_d;
  logic       tx_stop2_q, tx_stop2_d;
  logic       txd_q;
  logic       tx_idle_q;
  logic       w_tx_bit_end;
  logic       w_tx_stop_end;
  logic [7:0] w_tx_mask;

  assign w_tx_bit_end  = w_tick && (tx_tick_q[3:0] == 4'hF);
  assign w_tx_stop_end = w_tick && (tx_tick_q == (tx_stop2_q ? 5'd31 : 5'd15));
  assign w_tx_mask     = 8'hFF >> (2'd3 - iDATA_BITS);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = w_tick ? tx_tick_q + 5'd1 : tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_pen_d   = tx_pen_q;
    tx_par_d   = tx_par_q;
    tx_stop2_d = tx_stop2_q;
    w_tx_load  = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_tick_d = 5'd0;
        w_tx_load = !w_tx_empty;
      end
      ST_START: begin
        if (w_tx_bit_end) begin
          tx_state_d = ST_DATA;
          tx_tick_d  = 5'd0;
          tx_bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_tx_bit_end) begin
          tx_tick_d  = 5'd0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == ({1'b0, tx_bits_q} + 3'd4))
            tx_state_d = tx_pen_q ? ST_PARITY : ST_STOP;
          else
            tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (w_tx_bit_end) begin
          tx_state_d = ST_STOP;
          tx_tick_d  = 5'd0;
        end
      end
      ST_STOP: begin
        if (w_tx_stop_end) begin
          tx_state_d = ST_IDLE;
          tx_tick_d  = 5'd0;
          // Chain straight into the next START so consecutive bytes are gapless.
          w_tx_load  = !w_tx_empty;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    if (w_tx_load) begin
      tx_state_d = ST_START;
      tx_tick_d  = 5'd0;
      tx_shift_d = w_tx_head;
      tx_bits_d  = iDATA_BITS;
      tx_pen_d   = iPARITY_EN;
      tx_stop2_d = iSTOP2;
      tx_par_d   = (^(w_tx_head & w_tx_mask)) ^ iPARITY_ODD;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      tx_state_q <= ST_IDLE;
      tx_tick_q  <= 5'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_bits_q  <= 2'd0;
      tx_pen_q   <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      txd_q      <= 1'b1;
      tx_idle_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      tx_pen_q   <= tx_pen_d;
      tx_par_q   <= tx_par_d;
      tx_stop2_q <= tx_stop2_d;
      // Pin is registered from the current state, so it lags the FSM by a clock.
      case (tx_state_q)
        ST_START:  txd_q <= 1'b0;
        ST_DATA:   txd_q <= tx_shift_q[0];
        ST_PARITY: txd_q <= tx_par_q;
        default:   txd_q <= 1'b1;
      endcase
      tx_idle_q <= (tx_state_q == ST_IDLE) && w_tx_empty;
    end
  end

  assign oUART_TXD = txd_q;
  assign oTX_IDLE  = tx_idle_q;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic [1:0] rx_sync_q;
  logic       w_rxd;
  logic [2:0] rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q,  rx_tick_d;   // wraps naturally every 16 ticks
  logic [2:0] rx_bit_q,   rx_bit_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_acc_q,   rx_acc_d;
  logic       rx_perr_q,  rx_perr_d;
  logic [1:0] rx_bits_q,  rx_bits_d;
  logic       rx_pen_q,   rx_pen_d;
  logic       rx_podd_q,  rx_podd_d;
  logic       w_rx_mid;
  logic       overrun_q;
  logic       irq_q;

  assign w_rxd      = rx_sync_q[1];
  assign w_rx_mid   = w_tick && (rx_tick_q == 4'hF);
  assign w_rx_entry = {!w_rxd, rx_perr_q, rx_data_q};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = w_tick ? rx_tick_q + 4'd1 : rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_acc_d   = rx_acc_q;
    rx_perr_d  = rx_perr_q;
    rx_bits_d  = rx_bits_q;
    rx_pen_d   = rx_pen_q;
    rx_podd_d  = rx_podd_q;
    w_rx_wr    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_tick_d = 4'd0;
        if (w_tick && !w_rxd) begin
          rx_state_d = ST_START;
          rx_bit_d   = 3'd0;
          rx_data_d  = 8'h00;
          rx_acc_d   = 1'b0;
          rx_perr_d  = 1'b0;
          rx_bits_d  = iDATA_BITS;
          rx_pen_d   = iPARITY_EN;
          rx_podd_d  = iPARITY_ODD;
        end
      end
      ST_START: begin
        // Eighth tick after the falling edge is mid-start; high there is noise.
        if (w_tick && (rx_tick_q == 4'd7)) begin
          rx_tick_d  = 4'd0;
          rx_state_d = w_rxd ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_rx_mid) begin
          rx_data_d[rx_bit_q] = w_rxd;
          rx_acc_d = rx_acc_q ^ w_rxd;
          if (rx_bit_q == ({1'b0, rx_bits_q} + 3'd4))
            rx_state_d = rx_pen_q ? ST_PARITY : ST_STOP;
          else
            rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (w_rx_mid) begin
          rx_perr_d  = w_rxd ^ rx_acc_q ^ rx_podd_q;
          rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_rx_mid) begin
          w_rx_wr    = 1'b1;
          rx_state_d = ST_IDLE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= ST_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_data_q  <= 8'h00;
      rx_acc_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_bits_q  <= 2'd0;
      rx_pen_q   <= 1'b0;
      rx_podd_q  <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], iUART_RXD};
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_acc_q   <= rx_acc_d;
      rx_perr_q  <= rx_perr_d;
      rx_bits_q  <= rx_bits_d;
      rx_pen_q   <= rx_pen_d;
      rx_podd_q  <= rx_podd_d;
      // A frame lost to a full FIFO beats a same-cycle clear.
      if (w_rx_wr && w_rx_full) overrun_q <= 1'b1;
      else if (iERR_CLEAR)      overrun_q <= 1'b0;
      irq_q <= (iIRQ_RX_EN && (!oRX_EMPTY || overrun_q)) || (iIRQ_TX_EN && tx_idle_q);
    end
  end

  assign oRX_OVERRUN = overrun_q;
  assign oIRQ_VALID  = irq_q;

endmodule

// ============================================================================
// Module   : dps_uart2_fifo
// Purpose  : Synchronous FIFO with occupancy count reaching P_DEPTH.
//            Push when full / pop when empty are ignored; clear wins.
// Ports    : clear_i, push_i/data_i, pop_i; data_o is the head (show-ahead),
//            cnt_o occupancy, full_o/empty_o status.
// Revision : 1.0 - initial release
// ============================================================================
module dps_uart2_fifo #(
  parameter int P_W       = 8,
  parameter int P_DEPTH   = 16,
  parameter int P_DEPTH_N = 4
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [P_W-1:0]       data_i,
  input  logic                 pop_i,
  output logic [P_W-1:0]       data_o,
  output logic [P_DEPTH_N:0]   cnt_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [P_DEPTH_N-1:0] PTR_ONE = P_DEPTH_N'(1);
  localparam logic [P_DEPTH_N:0]   CNT_ONE = (P_DEPTH_N+1)'(1);
  localparam logic [P_DEPTH_N:0]   CNT_MAX = (P_DEPTH_N+1)'(P_DEPTH);

  logic [P_W-1:0]       mem_q [P_DEPTH];
  logic [P_DEPTH_N-1:0] wptr_q, rptr_q;
  logic [P_DEPTH_N:0]   cnt_q;
  logic                 w_push, w_pop;

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + PTR_ONE;
      if (w_pop)  rptr_q <= rptr_q + PTR_ONE;
      if (w_push && !w_pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (w_pop && !w_push) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_push && !clear_i) mem_q[wptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_dps_uart2.sv
`default_nettype none
// ============================================================================
// Module   : tb_dps_uart2
// Purpose  : Self-checking bench for dps_uart2. Frames are predicted from the
//            line-format rules (bit lists built per byte/format) and received
//            bytes from masked data plus forced error conditions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dps_uart2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] div;
  logic [1:0]  dbits;
  logic        pen, podd, stop2;
  logic        tx_en, tx_clear, tx_req;
  logic [7:0]  tx_data;
  logic        tx_full, tx_idle;
  logic [4:0]  tx_cnt, rx_cnt;
  logic        rx_en, rx_clear, rx_req;
  logic        rx_empty, rx_perr, rx_ferr, rx_ovr;
  logic [7:0]  rx_data;
  logic        err_clear, irq_rx_en, irq_tx_en, irq;
  logic        txd, rxd_drv, loop;
  logic        rxd_line;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign rxd_line = loop ? txd : rxd_drv;

  dps_uart2 #(.P_DEPTH(16), .P_DEPTH_N(4), .P_DIV_W(16)) dut (
    .iCLOCK(clk), .inRESET(rstn), .iDIVISOR(div), .iDATA_BITS(dbits),
    .iPARITY_EN(pen), .iPARITY_ODD(podd), .iSTOP2(stop2),
    .iTX_EN(tx_en), .iTX_CLEAR(tx_clear), .iTX_REQ(tx_req), .iTX_DATA(tx_data),
    .oTX_FULL(tx_full), .oTX_BUFF_CNT(tx_cnt), .oTX_IDLE(tx_idle),
    .iRX_EN(rx_en), .iRX_CLEAR(rx_clear), .iRX_REQ(rx_req),
    .oRX_EMPTY(rx_empty), .oRX_DATA(rx_data), .oRX_PERR(rx_perr), .oRX_FERR(rx_ferr),
    .oRX_BUFF_CNT(rx_cnt), .oRX_OVERRUN(rx_ovr), .iERR_CLEAR(err_clear),
    .iIRQ_RX_EN(irq_rx_en), .iIRQ_TX_EN(irq_tx_en), .oIRQ_VALID(irq),
    .oUART_TXD(txd), .iUART_RXD(rxd_line)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mask_of(input logic [1:0] db);
    int n;
    n = int'(db) + 5;
    return 8'((1 << n) - 1);
  endfunction

  function automatic logic parity_of(input logic [7:0] b, input logic [1:0] db, input logic odd);
    return odd ^ (($countones(b & mask_of(db)) % 2) == 1);
  endfunction

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk);
    tx_req  = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_req  = 1'b0;
  endtask

  task automatic pop_rx();
    rx_req = 1'b1;
    @(negedge clk);
    rx_req = 1'b0;
  endtask

  // Samples each transmitted bit at its centre against the predicted bit list.
  task automatic tx_frame_check(input logic [7:0] b, input string tag);
    bit exp_bits[$];
    int L, t, pos, target;
    L = int'(div) + 1;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < int'(dbits) + 5; i++) exp_bits.push_back(b[i]);
    if (pen) exp_bits.push_back(parity_of(b, dbits, podd));
    exp_bits.push_back(1'b1);
    if (stop2) exp_bits.push_back(1'b1);
    t = 0;
    while (txd !== 1'b0 && t < 20000) begin @(negedge clk); t++; end
    check($sformatf("%s_start_seen", tag), txd, 0);
    pos = 0;
    for (int i = 0; i < exp_bits.size(); i++) begin
      target = i * 16 * L + 8 * L;
      repeat (target - pos) @(negedge clk);
      pos = target;
      check($sformatf("%s_bit%0d", tag, i), txd, exp_bits[i]);
    end
    if (stop2) check($sformatf("%s_busy_in_stop2", tag), tx_idle, 0);
  endtask

  task automatic rx_expect(input logic [7:0] d, input logic pe, input logic fe, input string tag);
    int t;
    t = 0;
    while (rx_empty && t < 20000) begin @(negedge clk); t++; end
    check($sformatf("%s_avail", tag), rx_empty, 0);
    check($sformatf("%s_data", tag), rx_data, d);
    check($sformatf("%s_perr", tag), rx_perr, pe);
    check($sformatf("%s_ferr", tag), rx_ferr, fe);
    pop_rx();
  endtask

  task automatic wait_tx_idle(input string tag);
    int t;
    t = 0;
    while (!tx_idle && t < 20000) begin @(negedge clk); t++; end
    check(tag, tx_idle, 1);
  endtask

  // Drives one serial frame on the RX pin using the current format inputs.
  task automatic drive_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int L;
    L = int'(div) + 1;
    rxd_drv = 1'b0;
    repeat (16 * L) @(negedge clk);
    for (int i = 0; i < int'(dbits) + 5; i++) begin
      rxd_drv = b[i];
      repeat (16 * L) @(negedge clk);
    end
    if (pen) begin
      rxd_drv = parity_of(b, dbits, podd) ^ bad_par;
      repeat (16 * L) @(negedge clk);
    end
    if (bad_stop) begin
      // Low across the centre of the stop bit only, so no new start follows.
      rxd_drv = 1'b0;
      repeat (12 * L) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (4 * L) @(negedge clk);
    end else begin
      rxd_drv = 1'b1;
      repeat (16 * L) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (16 * L) @(negedge clk);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int t;
    rstn = 1'b0; div = 16'd0; dbits = 2'd3; pen = 1'b0; podd = 1'b0; stop2 = 1'b0;
    tx_en = 1'b1; tx_clear = 1'b0; tx_req = 1'b0; tx_data = 8'h00;
    rx_en = 1'b1; rx_clear = 1'b0; rx_req = 1'b0; err_clear = 1'b0;
    irq_rx_en = 1'b0; irq_tx_en = 1'b0; rxd_drv = 1'b1; loop = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tx_idle", tx_idle, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_cnt", tx_cnt, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_perr", rx_perr, 0);
    check("rst_rx_ferr", rx_ferr, 0);
    check("rst_rx_cnt", rx_cnt, 0);
    check("rst_ovr", rx_ovr, 0);
    check("rst_irq", irq, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // ---- 8N1 divisor 0, 0xA5 with exact start latency, loopback ----
    tx_req = 1'b1; tx_data = 8'hA5;
    @(negedge clk);                        // edge k accepted the push
    tx_req = 1'b0;
    check("a5_cnt_k", tx_cnt, 1);
    check("a5_idle_k", tx_idle, 1);
    check("a5_txd_k", txd, 1);
    @(negedge clk);                        // after edge k+1
    check("a5_idle_k1", tx_idle, 0);
    check("a5_txd_k1", txd, 1);
    check("a5_cnt_k1", tx_cnt, 0);
    @(negedge clk);                        // after edge k+2
    check("a5_txd_k2", txd, 0);
    tx_frame_check(8'hA5, "a5");
    rx_expect(8'hA5, 1'b0, 1'b0, "a5_rx");
    wait_tx_idle("a5_idle_end");

    // ---- RX overrun: 17 frames, nothing popped ----
    loop = 1'b0; irq_rx_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) q.push_back(b);
      drive_frame(b, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("ovr_cnt", rx_cnt, 16);
    check("ovr_flag", rx_ovr, 1);
    check("ovr_irq", irq, 1);
    check("ovr_head", rx_data, q[0]);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("ovr_cleared", rx_ovr, 0);
    check("ovr_head_kept", rx_data, q[0]);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_cnt", i), rx_cnt, 16 - i);
      check($sformatf("drain%0d_data", i), rx_data, q[i]);
      pop_rx();
    end
    check("drain_empty", rx_empty, 1);
    check("drain_data0", rx_data, 0);
    pop_rx();                              // pop on empty is ignored
    check("drain_cnt0", rx_cnt, 0);
    @(negedge clk);
    check("drain_irq_low", irq, 0);
    irq_rx_en = 1'b0;

    // ---- receive errors and glitch rejection, divisor 1 ----
    div = 16'd1;
    drive_frame(8'h3C, 1'b0, 1'b1);
    rx_expect(8'h3C, 1'b0, 1'b1, "ferr");
    repeat (80) @(negedge clk);
    check("ferr_no_extra", rx_empty, 1);
    pen = 1'b1; podd = 1'b0;
    drive_frame(8'h96, 1'b1, 1'b0);
    rx_expect(8'h96, 1'b1, 1'b0, "perr");
    pen = 1'b0;
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (80) @(negedge clk);
    check("glitch_empty", rx_empty, 1);
    check("glitch_cnt", rx_cnt, 0);

    // ---- randomized loopback frames ----
    loop = 1'b1;
    for (int r = 0; r < 5; r++) begin
      dbits = 2'($urandom_range(0, 3));
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      stop2 = 1'($urandom_range(0, 1));
      b     = 8'($urandom);
      push_tx(b);
      tx_frame_check(b, $sformatf("rnd%0d", r));
      rx_expect(b & mask_of(dbits), 1'b0, 1'b0, $sformatf("rnd%0d_rx", r));
      wait_tx_idle($sformatf("rnd%0d_idle", r));
    end

    // ---- 7E2 0x7F and 5O1 0xFF ----
    dbits = 2'd2; pen = 1'b1; podd = 1'b0; stop2 = 1'b1;
    push_tx(8'h7F);
    tx_frame_check(8'h7F, "7e2");
    rx_expect(8'h7F, 1'b0, 1'b0, "7e2_rx");
    wait_tx_idle("7e2_idle");
    dbits = 2'd0; pen = 1'b1; podd = 1'b1; stop2 = 1'b0;
    push_tx(8'hFF);
    tx_frame_check(8'hFF, "5o1");
    rx_expect(8'h1F, 1'b0, 1'b0, "5o1_rx");
    wait_tx_idle("5o1_idle");

    // ---- TX FIFO full / clear with a slow line ----
    dbits = 2'd3; pen = 1'b0; podd = 1'b0; stop2 = 1'b0;
    loop = 1'b0; div = 16'd15;
    push_tx(8'h11);
    repeat (2) @(negedge clk);
    check("full_busy", tx_idle, 0);
    check("full_start_cnt", tx_cnt, 0);
    tx_en = 1'b0;
    push_tx(8'h22);
    check("gated_push", tx_cnt, 0);
    tx_en = 1'b1;
    for (int i = 0; i < 16; i++) push_tx(8'(8'h30 + i));
    check("full_flag", tx_full, 1);
    check("full_cnt", tx_cnt, 16);
    push_tx(8'hEE);
    check("full_17th_cnt", tx_cnt, 16);
    check("full_17th_flag", tx_full, 1);
    tx_clear = 1'b1; tx_req = 1'b1;
    @(negedge clk);
    tx_clear = 1'b0; tx_req = 1'b0;
    check("clear_cnt", tx_cnt, 0);
    check("clear_full", tx_full, 0);
    check("clear_frame_live", tx_idle, 0);
    wait_tx_idle("clear_frame_done");
    check("clear_txd_high", txd, 1);

    // ---- asynchronous reset mid-frame ----
    loop = 1'b1;
    push_tx(8'h5A);
    push_tx(8'hC3);
    push_tx(8'h0F);
    t = 0;
    while (rx_empty && t < 20000) begin @(negedge clk); t++; end
    check("arst_pre_rx", rx_empty, 0);
    repeat (300) @(negedge clk);
    check("arst_pre_txd", txd, 0);
    check("arst_pre_cnt", tx_cnt, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_txd", txd, 1);
    check("arst_tx_cnt", tx_cnt, 0);
    check("arst_tx_idle", tx_idle, 1);
    check("arst_rx_empty", rx_empty, 1);
    check("arst_rx_cnt", rx_cnt, 0);
    check("arst_rx_data", rx_data, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
